// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- RV32I instruction-decode stage.
//
// Decodes the instruction handed over by fetch, reads the 32x32 register
// file (with same-cycle write-back bypass) and builds the sign-extended
// immediate. Everything is registered into the ID/EX boundary (1-cycle
// latency).
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   is_flush, is_stall    : pipeline control (reset > flush > stall)
//   if_valid/if_pc/if_instr : fetch-stage output
//   wb_we/wb_rd/wb_data   : register-file write port from write-back
//   id_*                  : ID/EX boundary outputs (valid, pc, register
//                           indices and operands, immediate, raw opcode
//                           fields, control bits, illegal flag)
// -----------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_flush,
  input  logic        is_stall,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic        id_funct7b5,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_is_branch,
  output logic        id_is_jump,
  output logic        id_illegal
);

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Immediate generator; every format sign-extends from instr[31].
  function automatic logic signed [DATA_W-1:0] imm_gen(input logic [31:0] ins);
    case (ins[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        imm_gen = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:
        imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:
        imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_gen = {ins[31:12], 12'b0};
      OPC_JAL:
        imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm_gen = '0;
    endcase
  endfunction

  // Register read with write-back bypass; x0 is hard-wired to zero.
  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0]        idx,
                                                input logic [DATA_W-1:0] stored,
                                                input logic              we,
                                                input logic [4:0]        wrd,
                                                input logic [DATA_W-1:0] wdata);
    if (idx == 5'd0)
      rf_read = '0;
    else if (we && (wrd == idx))
      rf_read = wdata;
    else
      rf_read = stored;
  endfunction

  logic [DATA_W-1:0] rf [32];

  // Write-back port: independent of stall/flush, only reset overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // ---- stage p0: combinational decode of the fetched instruction ----
  logic [6:0]               opcode_p0;
  logic [4:0]               rs1_p0, rs2_p0, rd_p0;
  logic [2:0]               funct3_p0;
  logic                     funct7b5_p0;
  logic [DATA_W-1:0]        rs1_data_p0, rs2_data_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic                     reg_write_p0, mem_read_p0, mem_write_p0;
  logic                     is_branch_p0, is_jump_p0, illegal_p0;
  logic                     writes_rd_p0;

  assign opcode_p0   = if_instr[6:0];
  assign rd_p0       = if_instr[11:7];
  assign funct3_p0   = if_instr[14:12];
  assign rs1_p0      = if_instr[19:15];
  assign rs2_p0      = if_instr[24:20];
  assign funct7b5_p0 = if_instr[30];
  assign imm_p0      = imm_gen(if_instr);
  assign rs1_data_p0 = rf_read(rs1_p0, rf[rs1_p0], wb_we, wb_rd, wb_data);
  assign rs2_data_p0 = rf_read(rs2_p0, rf[rs2_p0], wb_we, wb_rd, wb_data);

  always_comb begin
    writes_rd_p0 = 1'b0;
    mem_read_p0  = 1'b0;
    mem_write_p0 = 1'b0;
    is_branch_p0 = 1'b0;
    is_jump_p0   = 1'b0;
    illegal_p0   = 1'b0;
    case (opcode_p0)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: writes_rd_p0 = 1'b1;
      OPC_LOAD:   begin writes_rd_p0 = 1'b1; mem_read_p0 = 1'b1; end
      OPC_STORE:  mem_write_p0 = 1'b1;
      OPC_BRANCH: is_branch_p0 = 1'b1;
      OPC_JAL, OPC_JALR: begin writes_rd_p0 = 1'b1; is_jump_p0 = 1'b1; end
      default:    illegal_p0 = 1'b1;
    endcase
  end

  // A write to x0 is architecturally a no-op, so suppress it here.
  assign reg_write_p0 = writes_rd_p0 && (rd_p0 != 5'd0);

  // ---- stage p1: ID/EX boundary registers ----
  logic                     vld_p1;
  logic [DATA_W-1:0]        pc_p1, rs1_data_p1, rs2_data_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [4:0]               rs1_p1, rs2_p1, rd_p1;
  logic [6:0]               opcode_p1;
  logic [2:0]               funct3_p1;
  logic                     funct7b5_p1;
  logic                     reg_write_p1, mem_read_p1, mem_write_p1;
  logic                     is_branch_p1, is_jump_p1, illegal_p1;

  // Reset, flush and an invalid fetch all load an all-zero bubble; the data
  // fields are cleared too so downstream never sees stale operands.
  always_ff @(posedge clk) begin
    if (reset || is_flush || (!is_stall && !if_valid)) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      opcode_p1    <= '0;
      funct3_p1    <= '0;
      funct7b5_p1  <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      is_branch_p1 <= 1'b0;
      is_jump_p1   <= 1'b0;
      illegal_p1   <= 1'b0;
    end else if (!is_stall) begin
      vld_p1       <= 1'b1;
      pc_p1        <= if_pc;
      rs1_p1       <= rs1_p0;
      rs2_p1       <= rs2_p0;
      rd_p1        <= rd_p0;
      rs1_data_p1  <= rs1_data_p0;
      rs2_data_p1  <= rs2_data_p0;
      imm_p1       <= imm_p0;
      opcode_p1    <= opcode_p0;
      funct3_p1    <= funct3_p0;
      funct7b5_p1  <= funct7b5_p0;
      reg_write_p1 <= reg_write_p0;
      mem_read_p1  <= mem_read_p0;
      mem_write_p1 <= mem_write_p0;
      is_branch_p1 <= is_branch_p0;
      is_jump_p1   <= is_jump_p0;
      illegal_p1   <= illegal_p0;
    end
  end

  assign id_valid     = vld_p1;
  assign id_pc        = pc_p1;
  assign id_rs1       = rs1_p1;
  assign id_rs2       = rs2_p1;
  assign id_rd        = rd_p1;
  assign id_rs1_data  = rs1_data_p1;
  assign id_rs2_data  = rs2_data_p1;
  assign id_imm       = imm_p1;
  assign id_opcode    = opcode_p1;
  assign id_funct3    = funct3_p1;
  assign id_funct7b5  = funct7b5_p1;
  assign id_reg_write = reg_write_p1;
  assign id_mem_read  = mem_read_p1;
  assign id_mem_write = mem_write_p1;
  assign id_is_branch = is_branch_p1;
  assign id_is_jump   = is_jump_p1;
  assign id_illegal   = illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
// A reference model computes the expected ID/EX contents for every driven
// cycle and pushes them into a scoreboard queue; each test task pops the
// entry after the clock edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, is_flush, is_stall, if_valid;
  logic [31:0] if_pc, if_instr;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_is_jump;
  logic        id_illegal;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        rw, mr, mw, br, jp, ill;
  } out_t;

  out_t        sb[$];
  out_t        last_exp;
  out_t        got, exp;
  logic [31:0] mdl_rf [32];
  int          checks = 0;
  int          errors = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .is_flush(is_flush), .is_stall(is_stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    sample = {id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
              id_imm, id_opcode, id_funct3, id_funct7b5, id_reg_write,
              id_mem_read, id_mem_write, id_is_branch, id_is_jump, id_illegal};
  endfunction

  function automatic logic [31:0] mdl_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wr == idx) return wd;
    return mdl_rf[idx];
  endfunction

  function automatic out_t mdl_decode(input logic [31:0] pc, input logic [31:0] ins,
                                      input logic we, input logic [4:0] wr,
                                      input logic [31:0] wd);
    out_t               o;
    logic signed [31:0] s;
    logic signed [12:0] bimm;
    logic signed [20:0] jimm;
    o = '0;
    o.valid = 1'b1;
    o.pc    = pc;
    o.rs1   = ins[19:15];
    o.rs2   = ins[24:20];
    o.rd    = ins[11:7];
    o.op    = ins[6:0];
    o.f3    = ins[14:12];
    o.f7b5  = ins[30];
    o.d1    = mdl_read(o.rs1, we, wr, wd);
    o.d2    = mdl_read(o.rs2, we, wr, wd);
    s = 0;
    case (o.op)
      7'h13: begin s = $signed(ins) >>> 20; o.rw = 1; end
      7'h03: begin s = $signed(ins) >>> 20; o.rw = 1; o.mr = 1; end
      7'h67: begin s = $signed(ins) >>> 20; o.rw = 1; o.jp = 1; end
      7'h23: begin s = $signed(ins) >>> 25; s = (s <<< 5) | 32'(ins[11:7]); o.mw = 1; end
      7'h63: begin bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; s = bimm; o.br = 1; end
      7'h37, 7'h17: begin s = ins & 32'hFFFF_F000; o.rw = 1; end
      7'h6F: begin jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; s = jimm;
                   o.rw = 1; o.jp = 1; end
      7'h33: o.rw = 1;
      default: o.ill = 1;
    endcase
    o.imm = s;
    if (o.rd == 0) o.rw = 0;
    return o;
  endfunction

  // Drive one cycle, record the model's expectation, advance past the edge.
  task automatic step(input logic rst, input logic fl, input logic st, input logic v,
                      input logic [31:0] pc, input logic [31:0] ins, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd);
    out_t e;
    reset = rst; is_flush = fl; is_stall = st; if_valid = v;
    if_pc = pc; if_instr = ins; wb_we = we; wb_rd = wr; wb_data = wd;
    if (rst || fl)   e = '0;
    else if (st)     e = last_exp;
    else if (!v)     e = '0;
    else             e = mdl_decode(pc, ins, we, wr, wd);
    sb.push_back(e);
    last_exp = e;
    if (rst) for (int i = 0; i < 32; i++) mdl_rf[i] = 32'd0;
    else if (we && wr != 0) mdl_rf[wr] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1, 32'h40, 32'h00500093, 1, 5'd3, 32'h1234);
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_addi();
    step(0, 0, 0, 1, 32'h0, 32'h00500093, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL addi: got %h expected %h", got, exp); end
    checks++;
    if ({id_valid, id_rd, id_imm, id_reg_write, id_rs1_data} !== {1'b1, 5'd1, 32'd5, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL addi_fields: got v=%b rd=%0d imm=%h rw=%b rs1d=%h required 1/1/5/1/0",
               id_valid, id_rd, id_imm, id_reg_write, id_rs1_data);
    end
  endtask

  task automatic test_bypass_store();
    step(0, 0, 0, 1, 32'h4, 32'h0020A423, 1, 5'd1, 32'hDEADBEEF);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_bypass: got %h expected %h", got, exp); end
    checks++;
    if ({id_rs1_data, id_imm, id_mem_write, id_reg_write} !== {32'hDEADBEEF, 32'd8, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sw_fields: got rs1d=%h imm=%h mw=%b rw=%b required deadbeef/8/1/0",
               id_rs1_data, id_imm, id_mem_write, id_reg_write);
    end
    // x1 now comes from the array rather than the bypass
    step(0, 0, 0, 1, 32'h8, 32'h00008113, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rf_read: got %h expected %h", got, exp); end
  endtask

  task automatic test_branch_lui();
    step(0, 0, 0, 1, 32'hC, 32'hFE000EE3, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL beq: got %h expected %h", got, exp); end
    checks++;
    if ({id_imm, id_is_branch} !== {32'hFFFFFFFC, 1'b1}) begin
      errors++; $display("FAIL beq_fields: got imm=%h br=%b required fffffffc/1", id_imm, id_is_branch);
    end
    step(0, 0, 0, 1, 32'h10, 32'h123451B7, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL lui: got %h expected %h", got, exp); end
    checks++;
    if ({id_imm, id_rd} !== {32'h12345000, 5'd3}) begin
      errors++; $display("FAIL lui_fields: got imm=%h rd=%0d required 12345000/3", id_imm, id_rd);
    end
  endtask

  task automatic test_stall_flush();
    step(0, 0, 0, 1, 32'h14, 32'h008000EF, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL jal: got %h expected %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 32'h100 + 32'(i), 32'h00028313 + 32'(i << 20), 1, 5'd5, 32'h55);
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, got, exp); end
    end
    step(0, 1, 1, 1, 32'h200, 32'h00500093, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL flush_stall: got %h expected %h", got, exp); end
    // writes made during the stall must have landed
    step(0, 0, 0, 1, 32'h18, 32'h00028313, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wb_during_stall: got %h expected %h", got, exp); end
    checks++;
    if (id_rs1_data !== 32'h55) begin
      errors++; $display("FAIL wb_during_stall_val: got %h required 00000055", id_rs1_data);
    end
  endtask

  task automatic test_x0();
    step(0, 0, 0, 1, 32'h1C, 32'h00500093, 1, 5'd0, 32'hFFFFFFFF);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL x0_write: got %h expected %h", got, exp); end
    checks++;
    if (id_rs1_data !== 32'd0) begin
      errors++; $display("FAIL x0_read: got %h required 00000000", id_rs1_data);
    end
    step(0, 0, 0, 1, 32'h20, 32'h00000013, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL nop: got %h expected %h", got, exp); end
    checks++;
    if (id_reg_write !== 1'b0) begin
      errors++; $display("FAIL nop_rw: got %b required 0", id_reg_write);
    end
  endtask

  task automatic test_illegal_reset();
    step(0, 0, 0, 1, 32'h24, 32'hFFFFFFFF, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL illegal: got %h expected %h", got, exp); end
    checks++;
    if ({id_illegal, id_valid, id_reg_write, id_mem_read, id_mem_write, id_is_branch, id_is_jump}
        !== 7'b1100000) begin
      errors++; $display("FAIL illegal_ctrl: got ill=%b v=%b rw=%b mr=%b mw=%b br=%b jp=%b required 1100000",
                         id_illegal, id_valid, id_reg_write, id_mem_read, id_mem_write,
                         id_is_branch, id_is_jump);
    end
    step(0, 0, 0, 0, 32'h28, 32'h00500093, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bubble: got %h expected %h", got, exp); end
    step(0, 0, 0, 1, 32'h2C, 32'h00408083, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL load: got %h expected %h", got, exp); end
    step(1, 0, 0, 1, 32'h30, 32'h00008113, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_mid: got %h expected %h", got, exp); end
    // register file must have been cleared by reset
    step(0, 0, 0, 1, 32'h34, 32'h00528113, 0, 5'd0, 32'h0);
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rf_cleared: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [11];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F, 7'h73};
    for (int i = 0; i < 80; i++) begin
      ins = $urandom();
      ins[6:0]   = ops[$urandom_range(0, 10)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step(0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0,
           $urandom(), ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp) begin errors++; $display("FAIL random%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_rf[i] = 32'd0;
    last_exp = '0;
    reset = 1; is_flush = 0; is_stall = 0; if_valid = 0;
    if_pc = 0; if_instr = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    test_reset();
    test_addi();
    test_bypass_store();
    test_branch_lui();
    test_stall_flush();
    test_x0();
    test_illegal_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and takes that stage's `is_valid`, `pc` and `instr`. It decodes the instruction, reads the 32×32 register file, and generates the sign-extended immediate. All results are registered into the ID/EX boundary. The register file's single write port is driven by write-back, with same-cycle write-to-read bypass.

## Interface
Parameters:
- none (XLEN fixed at 32, 32 architectural registers)

Ports:
- `clk` in 1: single clock, all state updates on its rising edge
- `reset` in 1: synchronous, active-high
- `is_flush` in 1: kill the instruction entering ID/EX this cycle
- `is_stall` in 1: hold ID/EX outputs
- `if_valid` in 1: fetch output is valid
- `if_pc` in 32: PC of the fetched instruction
- `if_instr` in 32: fetched instruction
- `wb_we` in 1: register-file write enable
- `wb_rd` in 5: write address
- `wb_data` in 32: write data
- `id_valid` out 1: ID/EX slot holds a live instruction
- `id_pc` out 32: PC of that instruction
- `id_rs1`, `id_rs2`, `id_rd` out 5 each: register indices
- `id_rs1_data`, `id_rs2_data` out 32: operand values
- `id_imm` out 32: sign-extended immediate
- `id_opcode` out 7, `id_funct3` out 3, `id_funct7b5` out 1: raw fields for EX ALU decode
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_is_branch`, `id_is_jump` out 1 each: control bits
- `id_illegal` out 1: opcode is not supported

## Operation
- Register file: 32×32 array; x0 reads 0 always.
  - Write occurs when `wb_we` is high and `wb_rd != 0`.
  - Writes proceed regardless of stall or flush.
- Bypass: if `wb_we` is high, `wb_rd != 0` and `wb_rd` equals the rs index, the read returns `wb_data` in the same cycle.
- Immediate by opcode (all formats sign-extend bit 31):
  - I-type for 0010011, 0000011, 1100111
  - S-type for 0100011
  - B-type for 1100011 (bit0 = 0)
  - U-type for 0110111, 0010111 (`imm = instr[31:12] << 12`)
  - J-type for 1101111 (bit0 = 0)
  - R-type: `id_imm = 0`
- Control:
  - `id_reg_write = 1` for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and forced to 0 when rd = 0.
  - `id_mem_read = 1` for LOAD only.
  - `id_mem_write = 1` for STORE only.
  - `id_is_branch = 1` for BRANCH.
  - `id_is_jump = 1` for JAL and JALR.
- Unsupported opcode: `id_illegal = 1`, all five control bits 0, `id_valid` follows `if_valid`.
- `if_valid` = 0: latch a bubble.
- Bubble: `id_valid = 0`, all control bits 0, `id_illegal = 0`. Data fields are don't-care but must be driven to 0.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Priority at each edge, highest first: `reset` > `is_flush` > `is_stall` > normal capture.
- `reset`: every output goes to 0 and every register-file entry is cleared to 0. Reset asserted mid-operation discards the in-flight instruction at that edge.
- `is_flush`: latch a bubble, even if `is_stall` is also high.
- `is_stall` (no flush): all outputs hold their previous values.
  - `id_rs1_data` and `id_rs2_data` are not re-read during the stall.
  - Write-back hazards across a stall are resolved by the downstream forwarding unit.
- Simultaneous write and read of the same register returns the new value (bypass). Write to x0 is ignored, and reads of x0 stay 0.

## Test plan
1. Reset held 2 cycles, then `if_instr = 0x00500093` (addi x1,x0,5) with `if_valid = 1` and `if_pc = 0x0`. Expected after one edge: `id_valid = 1`, `id_rd = 1`, `id_imm = 5`, `id_reg_write = 1`, `id_rs1_data = 0`.
2. Write `wb_we = 1`, `wb_rd = 1`, `wb_data = 0xDEADBEEF` in the same cycle as `if_instr = 0x0020A423` (sw x2,8(x1)). Expected: `id_rs1_data = 0xDEADBEEF` (bypass), `id_imm = 8`, `id_mem_write = 1`, `id_reg_write = 0`.
3. `if_instr = 0xFE000EE3` (beq x0,x0,-4). Expected: `id_imm = 0xFFFFFFFC`, `id_is_branch = 1`. Then `0x123451B7` (lui x3). Expected: `id_imm = 0x12345000`, `id_rd = 3`.
4. Hold `is_stall = 1` for 3 cycles while `if_instr` changes. Expected: outputs unchanged. Then assert `is_stall` and `is_flush` together. Expected: `id_valid = 0` and all control bits 0.
5. Write `wb_we = 1`, `wb_rd = 0`, `wb_data = 0xFFFFFFFF`, then decode an instruction reading x0. Expected: `id_rs1_data = 0`. Then `if_instr = 0x00000013` (nop). Expected: `id_reg_write = 0`.
6. `if_instr = 0xFFFFFFFF` with `if_valid = 1`. Expected: `id_illegal = 1`, `id_valid = 1`, all control bits 0. Then assert `reset` mid-stream. Expected: all outputs 0 at the next edge.
